reg_writeback_queue: RTL and testbench

REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

---
 rtl/reg_writeback_queue.sv | 104 ++++++++++
 tb/tb_reg_writeback_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_writeback_queue: in-order register-file writeback queue with          |
// | youngest-match forwarding for two decode read ports.   Revision: 1.0      |
// +----------------------------------------------------------------------------+
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       drain_en,
  output logic       RegWrite,
  output logic [2:0] WriteAddr,
  output logic [7:0] WriteData,
  input  logic [2:0] rd_addr1,
  input  logic [2:0] rd_addr2,
  output logic       hit1,
  output logic       hit2,
  output logic [7:0] fwd_data1,
  output logic [7:0] fwd_data2,
  output logic [3:0] pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [3:0]       pending_q, pending_d;
  logic [DEPTH-1:0] valid_q;
  logic [2:0]       addr_q [DEPTH];
  logic [7:0]       data_q [DEPTH];
  logic             push;
  logic             pop;
  logic [PW-1:0]    idx;

  assign wr_ready  = (pending_q != 4'(DEPTH));
  assign push      = wr_valid && wr_ready;
  assign RegWrite  = (pending_q != 4'd0) && drain_en;
  assign pop       = RegWrite;
  assign WriteAddr = (pending_q != 4'd0) ? addr_q[head_q] : 3'd0;
  assign WriteData = (pending_q != 4'd0) ? data_q[head_q] : 8'd0;
  assign pending   = pending_q;

  always_comb begin
    head_d    = pop  ? head_q + PW'(1) : head_q;
    tail_d    = push ? tail_q + PW'(1) : tail_q;
    pending_d = pending_q;
    case ({push, pop})
      2'b10:   pending_d = pending_q + 4'd1;
      2'b01:   pending_d = pending_q - 4'd1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      pending_q <= 4'd0;
      valid_q   <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      pending_q <= pending_d;
      // push and pop never share a slot: that would need the queue both empty and full
      if (pop)  valid_q[head_q] <= 1'b0;
      if (push) valid_q[tail_q] <= 1'b1;
    end
  end

  // Payload needs no reset; the valid bits and pending count qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= wr_addr;
      data_q[tail_q] <= wr_data;
    end
  end

  // Scan oldest to youngest so the most recently pushed match wins.
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    fwd_data1 = 8'd0;
    fwd_data2 = 8'd0;
    idx       = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && (addr_q[idx] == rd_addr1)) begin
        hit1      = 1'b1;
        fwd_data1 = data_q[idx];
      end
      if (valid_q[idx] && (addr_q[idx] == rd_addr2)) begin
        hit2      = 1'b1;
        fwd_data2 = data_q[idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
`default_nettype none
// Testbench for reg_writeback_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       drain_en;
  logic       RegWrite;
  logic [2:0] WriteAddr;
  logic [7:0] WriteData;
  logic [2:0] rd_addr1;
  logic [2:0] rd_addr2;
  logic       hit1;
  logic       hit2;
  logic [7:0] fwd_data1;
  logic [7:0] fwd_data2;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;
  logic [10:0] mq[$];

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .drain_en(drain_en), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hit1(hit1), .hit2(hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .pending(pending)
  );

  always #5 clk = ~clk;

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit do_push, do_pop;
    do_push = reset && wr_valid && (mq.size() != DEPTH);
    do_pop  = reset && drain_en && (mq.size() != 0);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({wr_addr, wr_data});
    @(negedge clk);
  endtask

  function automatic void model_look(input logic [2:0] a, output logic h, output logic [7:0] d);
    h = 1'b0;
    d = 8'd0;
    foreach (mq[i]) if (mq[i][10:8] == a) begin h = 1'b1; d = mq[i][7:0]; end
  endfunction

  task automatic test_reset();
    reset = 1'b0; wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 8'hAA; drain_en = 1'b1;
    rd_addr1 = 3'd1; rd_addr2 = 3'd1;
    #3;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", RegWrite); end
    checks++; if (pending !== 4'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", pending); end
    checks++; if ({WriteAddr, WriteData} !== 11'd0) begin errors++; $display("FAIL reset_wport got %h/%h exp 0/0", WriteAddr, WriteData); end
    checks++; if ({hit1, hit2, fwd_data1, fwd_data2} !== 18'd0) begin errors++; $display("FAIL reset_fwd got %b%b %h %h exp all 0", hit1, hit2, fwd_data1, fwd_data2); end
    @(negedge clk);
    #1; // held in reset across an edge with wr_valid high: nothing accepted
    checks++; if (pending !== 4'd0) begin errors++; $display("FAIL reset_hold_pending got %0d exp 0", pending); end
    reset = 1'b1; wr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A; drain_en = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b0 || WriteData !== 8'h00) begin errors++; $display("FAIL single_nobypass got %b/%h exp 0/00", RegWrite, WriteData); end
    tick();
    wr_valid = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL single_regwrite got %b exp 1", RegWrite); end
    checks++; if (WriteAddr !== 3'd3 || WriteData !== 8'h5A) begin errors++; $display("FAIL single_wport got %h/%h exp 3/5a", WriteAddr, WriteData); end
    checks++; if (pending !== 4'd1) begin errors++; $display("FAIL single_pending1 got %0d exp 1", pending); end
    tick();
    #1;
    checks++; if (pending !== 4'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL single_drained got %0d/%b exp 0/0", pending, RegWrite); end
  endtask

  task automatic test_fill();
    drain_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 8'h10 + 8'(i);
      #1;
      checks++; if (wr_ready !== (i < 4)) begin errors++; $display("FAIL fill_ready i=%0d got %b exp %b", i, wr_ready, (i < 4)); end
      tick();
    end
    wr_valid = 1'b0;
    #1;
    checks++; if (pending !== 4'd4) begin errors++; $display("FAIL fill_pending got %0d exp 4", pending); end
    checks++; if (RegWrite !== 1'b0 || WriteData !== 8'h10) begin errors++; $display("FAIL fill_hold got %b/%h exp 0/10", RegWrite, WriteData); end
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (RegWrite !== 1'b1 || WriteAddr !== 3'(i) || WriteData !== 8'h10 + 8'(i))
        begin errors++; $display("FAIL fill_drain i=%0d got %b %h/%h exp 1 %h/%h", i, RegWrite, WriteAddr, WriteData, i, 8'h10 + 8'(i)); end
      tick();
    end
    #1;
    checks++; if (pending !== 4'd0) begin errors++; $display("FAIL fill_empty got %0d exp 0", pending); end
  endtask

  task automatic test_forward();
    drain_en = 1'b0;
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 8'h11; tick();
    wr_data = 8'h22; tick();
    wr_addr = 3'd6; wr_data = 8'h99; // same-cycle write must not be visible
    rd_addr1 = 3'd2; rd_addr2 = 3'd6;
    #1;
    checks++; if (hit1 !== 1'b1 || fwd_data1 !== 8'h22) begin errors++; $display("FAIL fwd_port1 got %b/%h exp 1/22", hit1, fwd_data1); end
    checks++; if (hit2 !== 1'b0 || fwd_data2 !== 8'h00) begin errors++; $display("FAIL fwd_port2 got %b/%h exp 0/00", hit2, fwd_data2); end
    wr_valid = 1'b0; drain_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (WriteData !== (i == 0 ? 8'h11 : 8'h22)) begin errors++; $display("FAIL fwd_order i=%0d got %h exp %h", i, WriteData, (i == 0 ? 8'h11 : 8'h22)); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[$];
    drain_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 8'($urandom); seq.push_back(wr_data); tick();
    end
    drain_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = 3'(i); wr_data = 8'h30 + 8'(i); seq.push_back(wr_data);
      #1;
      checks++; if (pending !== 4'd2) begin errors++; $display("FAIL b2b_pending i=%0d got %0d exp 2", i, pending); end
      checks++; if (RegWrite !== 1'b1 || WriteData !== seq[i]) begin errors++; $display("FAIL b2b_order i=%0d got %b/%h exp 1/%h", i, RegWrite, WriteData, seq[i]); end
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      #1;
      checks++; if (WriteData !== seq[i]) begin errors++; $display("FAIL b2b_tail i=%0d got %h exp %h", i, WriteData, seq[i]); end
      tick();
    end
  endtask

  task automatic test_random();
    logic       eh1, eh2;
    logic [7:0] ed1, ed2;
    logic [10:0] hd;
    for (int c = 0; c < 400; c++) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      drain_en = ($urandom_range(0, 1) != 0);
      wr_addr  = 3'($urandom_range(0, 3));
      wr_data  = 8'($urandom);
      rd_addr1 = 3'($urandom_range(0, 4));
      rd_addr2 = 3'($urandom_range(0, 4));
      #1;
      model_look(rd_addr1, eh1, ed1);
      model_look(rd_addr2, eh2, ed2);
      hd = (mq.size() != 0) ? mq[0] : 11'd0;
      checks++; if (wr_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rand_ready c=%0d got %b exp %b", c, wr_ready, (mq.size() != DEPTH)); end
      checks++; if (pending !== 4'(mq.size())) begin errors++; $display("FAIL rand_pending c=%0d got %0d exp %0d", c, pending, mq.size()); end
      checks++; if (RegWrite !== (drain_en && mq.size() != 0)) begin errors++; $display("FAIL rand_regwrite c=%0d got %b", c, RegWrite); end
      checks++; if ({WriteAddr, WriteData} !== hd) begin errors++; $display("FAIL rand_wport c=%0d got %h/%h exp %h/%h", c, WriteAddr, WriteData, hd[10:8], hd[7:0]); end
      checks++; if ({hit1, fwd_data1} !== {eh1, ed1}) begin errors++; $display("FAIL rand_fwd1 c=%0d got %b/%h exp %b/%h", c, hit1, fwd_data1, eh1, ed1); end
      checks++; if ({hit2, fwd_data2} !== {eh2, ed2}) begin errors++; $display("FAIL rand_fwd2 c=%0d got %b/%h exp %b/%h", c, hit2, fwd_data2, eh2, ed2); end
      tick();
    end
    wr_valid = 1'b0; drain_en = 1'b1;
    repeat (DEPTH) tick();
  endtask

  task automatic test_reset_mid();
    drain_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 8'h40 + 8'(i); tick();
    end
    wr_valid = 1'b0; drain_en = 1'b1; rd_addr1 = 3'd1; rd_addr2 = 3'd3;
    #1;
    checks++; if (pending !== 4'd3 || RegWrite !== 1'b1 || hit1 !== 1'b1) begin errors++; $display("FAIL rmid_pre got %0d/%b/%b exp 3/1/1", pending, RegWrite, hit1); end
    #1;
    reset = 1'b0; mq.delete();
    #1;
    checks++; if (RegWrite !== 1'b0 || hit1 !== 1'b0 || hit2 !== 1'b0) begin errors++; $display("FAIL rmid_drop got %b%b%b exp 000", RegWrite, hit1, hit2); end
    checks++; if (pending !== 4'd0 || wr_ready !== 1'b1 || WriteData !== 8'h00) begin errors++; $display("FAIL rmid_state got %0d/%b/%h exp 0/1/00", pending, wr_ready, WriteData); end
    tick();
    reset = 1'b1; wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 8'h77;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rmid_nowrite got %b exp 0", RegWrite); end
    tick();
    wr_valid = 1'b0;
    #1;
    checks++; if (pending !== 4'd1 || WriteAddr !== 3'd7 || WriteData !== 8'h77) begin errors++; $display("FAIL rmid_first_push got %0d %h/%h exp 1 7/77", pending, WriteAddr, WriteData); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
